// File: rtl/rename_reg_file.sv
`default_nettype none
// ============================================================================
//  Module      : rename_reg_file
//  Description : Architectural register file x0..x31 with per-register rename
//                tags. It takes the ROB head commit broadcast, records new
//                destination renames from issue, and serves two combinational
//                operand lookups (value, or busy + pending producer tag).
//                Optional macro REGFILE_COMMIT_BYPASS_EN forwards a matching
//                same-cycle commit straight onto the read ports.
//  Revision    : 1.0 - initial release
// ============================================================================
module rename_reg_file #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 4,
    parameter int NREG  = 32
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             predict_fail,
    input  logic             commit_valid,
    input  logic [TAG_W-1:0] commit_tag,
    input  logic [4:0]       commit_rd,
    input  logic [XLEN-1:0]  commit_val,
    input  logic             issue_valid,
    input  logic [4:0]       issue_rd,
    input  logic [TAG_W-1:0] issue_tag,
    input  logic [4:0]       rs1_idx,
    input  logic [4:0]       rs2_idx,
    output logic [XLEN-1:0]  rs1_val,
    output logic             rs1_busy,
    output logic [TAG_W-1:0] rs1_tag,
    output logic [XLEN-1:0]  rs2_val,
    output logic             rs2_busy,
    output logic [TAG_W-1:0] rs2_tag,
    output logic [31:0]      retire_cnt
);

    // ------------------------------------------------------------------------
    // Architectural state
    // ------------------------------------------------------------------------
    logic [XLEN-1:0]  val_q [NREG];
    logic [XLEN-1:0]  val_d [NREG];
    logic [NREG-1:0]  busy_q;
    logic [NREG-1:0]  busy_d;
    logic [TAG_W-1:0] tag_q [NREG];
    logic [TAG_W-1:0] tag_d [NREG];
    logic [31:0]      retire_cnt_q;
    logic [31:0]      retire_cnt_d;

    // ------------------------------------------------------------------------
    // Qualified events. Everything is gated by rdy_in so a stalled pipeline
    // leaves the file untouched. A flush drops any same-cycle rename because
    // that rename belongs to the squashed path.
    // ------------------------------------------------------------------------
    logic w_commit_en;
    logic w_commit_hit;
    logic w_flush;
    logic w_rename_en;

    assign w_commit_en  = rdy_in & commit_valid;
    assign w_commit_hit = w_commit_en && (commit_rd != 5'd0) &&
                          busy_q[commit_rd] && (tag_q[commit_rd] == commit_tag);
    assign w_flush      = rdy_in & predict_fail;
    assign w_rename_en  = rdy_in & issue_valid & ~predict_fail & (issue_rd != 5'd0);

    // Next-state: commit writes the value, a matching commit clears the
    // rename, flush clears all renames, and a rename is applied last so it
    // overrides a same-register commit in the same cycle.
    always_comb begin
        val_d        = val_q;
        busy_d       = busy_q;
        tag_d        = tag_q;
        retire_cnt_d = retire_cnt_q;

        if (w_commit_en) begin
            retire_cnt_d = retire_cnt_q + 32'd1;
            if (commit_rd != 5'd0) begin
                val_d[commit_rd] = commit_val;
            end
        end

        // An older producer retiring (tag mismatch) leaves the rename alone.
        if (w_commit_hit) begin
            busy_d[commit_rd] = 1'b0;
            tag_d[commit_rd]  = '0;
        end

        if (w_flush) begin
            busy_d = '0;
            for (int i = 0; i < NREG; i++) begin
                tag_d[i] = '0;
            end
        end

        if (w_rename_en) begin
            busy_d[issue_rd] = 1'b1;
            tag_d[issue_rd]  = issue_tag;
        end
    end

    // State register with asynchronous clear.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < NREG; i++) begin
                val_q[i] <= '0;
                tag_q[i] <= '0;
            end
            busy_q       <= '0;
            retire_cnt_q <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                val_q[i] <= val_d[i];
                tag_q[i] <= tag_d[i];
            end
            busy_q       <= busy_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    assign retire_cnt = retire_cnt_q;

    // Operand port 1: registered lookup, optional commit forwarding, x0 and
    // reset force an all-zero answer.
    always_comb begin
        rs1_val  = val_q[rs1_idx];
        rs1_busy = busy_q[rs1_idx];
        rs1_tag  = tag_q[rs1_idx];
`ifdef REGFILE_COMMIT_BYPASS_EN
        if (w_commit_hit && (rs1_idx == commit_rd)) begin
            rs1_val  = commit_val;
            rs1_busy = 1'b0;
            rs1_tag  = '0;
        end
`endif
        if (rst_in || (rs1_idx == 5'd0)) begin
            rs1_val  = '0;
            rs1_busy = 1'b0;
            rs1_tag  = '0;
        end
    end

    // Operand port 2: identical to port 1, fully independent of it.
    always_comb begin
        rs2_val  = val_q[rs2_idx];
        rs2_busy = busy_q[rs2_idx];
        rs2_tag  = tag_q[rs2_idx];
`ifdef REGFILE_COMMIT_BYPASS_EN
        if (w_commit_hit && (rs2_idx == commit_rd)) begin
            rs2_val  = commit_val;
            rs2_busy = 1'b0;
            rs2_tag  = '0;
        end
`endif
        if (rst_in || (rs2_idx == 5'd0)) begin
            rs2_val  = '0;
            rs2_busy = 1'b0;
            rs2_tag  = '0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rename_reg_file.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rename_reg_file
//  Description : Self-checking bench for rename_reg_file. Directed scenarios
//                plus a randomized back-to-back run against a reference model;
//                expectations go through a scoreboard queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rename_reg_file;

    localparam int XLEN  = 32;
    localparam int TAG_W = 4;

    localparam int S_R1V = 0;
    localparam int S_R1B = 1;
    localparam int S_R1T = 2;
    localparam int S_R2V = 3;
    localparam int S_R2B = 4;
    localparam int S_R2T = 5;
    localparam int S_CNT = 6;

    logic             clk_in = 1'b0;
    logic             rst_in;
    logic             rdy_in;
    logic             predict_fail;
    logic             commit_valid;
    logic [TAG_W-1:0] commit_tag;
    logic [4:0]       commit_rd;
    logic [XLEN-1:0]  commit_val;
    logic             issue_valid;
    logic [4:0]       issue_rd;
    logic [TAG_W-1:0] issue_tag;
    logic [4:0]       rs1_idx;
    logic [4:0]       rs2_idx;
    logic [XLEN-1:0]  rs1_val;
    logic             rs1_busy;
    logic [TAG_W-1:0] rs1_tag;
    logic [XLEN-1:0]  rs2_val;
    logic             rs2_busy;
    logic [TAG_W-1:0] rs2_tag;
    logic [31:0]      retire_cnt;

    rename_reg_file #(.XLEN(XLEN), .TAG_W(TAG_W), .NREG(32)) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .rdy_in       (rdy_in),
        .predict_fail (predict_fail),
        .commit_valid (commit_valid),
        .commit_tag   (commit_tag),
        .commit_rd    (commit_rd),
        .commit_val   (commit_val),
        .issue_valid  (issue_valid),
        .issue_rd     (issue_rd),
        .issue_tag    (issue_tag),
        .rs1_idx      (rs1_idx),
        .rs2_idx      (rs2_idx),
        .rs1_val      (rs1_val),
        .rs1_busy     (rs1_busy),
        .rs1_tag      (rs1_tag),
        .rs2_val      (rs2_val),
        .rs2_busy     (rs2_busy),
        .rs2_tag      (rs2_tag),
        .retire_cnt   (retire_cnt)
    );

    always #5 clk_in = ~clk_in;

    // Scoreboard
    typedef struct {
        string       name;
        int          sel;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model of the architectural state
    logic [31:0] m_val  [32];
    logic        m_busy [32];
    logic [3:0]  m_tag  [32];
    logic [31:0] m_cnt;

    function automatic void push_exp(input string name, input int sel, input logic [31:0] v);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.val  = v;
        sb.push_back(e);
    endfunction

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            S_R1V:   return rs1_val;
            S_R1B:   return {31'd0, rs1_busy};
            S_R1T:   return {28'd0, rs1_tag};
            S_R2V:   return rs2_val;
            S_R2B:   return {31'd0, rs2_busy};
            S_R2T:   return {28'd0, rs2_tag};
            default: return retire_cnt;
        endcase
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) begin
            m_val[i]  = '0;
            m_busy[i] = 1'b0;
            m_tag[i]  = '0;
        end
        m_cnt = '0;
    endfunction

    // Does the current commit retire the producer the model has on record?
    function automatic bit model_hit(input logic [4:0] i);
        return rdy_in && commit_valid && (i != 0) && (i == commit_rd) &&
               m_busy[i] && (m_tag[i] == commit_tag);
    endfunction

    function automatic logic [31:0] m_rd_val(input logic [4:0] i);
        if (i == 0) return '0;
`ifdef REGFILE_COMMIT_BYPASS_EN
        if (model_hit(i)) return commit_val;
`endif
        return m_val[i];
    endfunction

    function automatic logic [31:0] m_rd_busy(input logic [4:0] i);
        if (i == 0) return '0;
`ifdef REGFILE_COMMIT_BYPASS_EN
        if (model_hit(i)) return '0;
`endif
        return {31'd0, m_busy[i]};
    endfunction

    function automatic logic [31:0] m_rd_tag(input logic [4:0] i);
        if (i == 0) return '0;
`ifdef REGFILE_COMMIT_BYPASS_EN
        if (model_hit(i)) return '0;
`endif
        return {28'd0, m_tag[i]};
    endfunction

    // Apply the effect of the upcoming clock edge to the model.
    function automatic void model_edge();
        bit hit;
        hit = model_hit(commit_rd);
        if (!rdy_in) return;
        if (commit_valid) begin
            m_cnt = m_cnt + 1;
            if (commit_rd != 0) m_val[commit_rd] = commit_val;
        end
        if (hit) begin
            m_busy[commit_rd] = 1'b0;
            m_tag[commit_rd]  = '0;
        end
        if (predict_fail) begin
            for (int i = 0; i < 32; i++) begin
                m_busy[i] = 1'b0;
                m_tag[i]  = '0;
            end
        end else if (issue_valid && issue_rd != 0) begin
            m_busy[issue_rd] = 1'b1;
            m_tag[issue_rd]  = issue_tag;
        end
    endfunction

    task automatic tick();
        model_edge();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle();
        rdy_in       = 1'b1;
        predict_fail = 1'b0;
        commit_valid = 1'b0;
        commit_tag   = '0;
        commit_rd    = '0;
        commit_val   = '0;
        issue_valid  = 1'b0;
        issue_rd     = '0;
        issue_tag    = '0;
    endtask

    task automatic test_reset();
        exp_t cur; logic [31:0] obs;
        idle();
        rst_in  = 1'b1;
        rs1_idx = 5'd3;
        rs2_idx = 5'd0;
        repeat (2) @(posedge clk_in);
        #1;
        push_exp("reset_rs1_val", S_R1V, 32'd0);
        push_exp("reset_rs1_busy", S_R1B, 32'd0);
        push_exp("reset_rs1_tag", S_R1T, 32'd0);
        push_exp("reset_cnt", S_CNT, 32'd0);
        while (sb.size() > 0) begin
            cur = sb.pop_front(); obs = observe(cur.sel); checks++;
            if (obs !== cur.val) begin failures++; $display("FAIL %s actual=%h expected=%h", cur.name, obs, cur.val); end
        end
        rst_in = 1'b0;
        model_reset();
        @(posedge clk_in);
        #1;
        // Rename x5 and retire into x10, then reset asynchronously mid-cycle.
        issue_valid = 1'b1; issue_rd = 5'd5; issue_tag = 4'd6;
        commit_valid = 1'b1; commit_rd = 5'd10; commit_tag = 4'd1; commit_val = 32'h77;
        push_exp("pre_rst_busy_x5", S_R1B, 32'd1);
        push_exp("pre_rst_tag_x5", S_R1T, 32'd6);
        push_exp("pre_rst_val_x10", S_R2V, 32'h77);
        push_exp("pre_rst_cnt", S_CNT, 32'd1);
        tick();
        idle();
        rs1_idx = 5'd5; rs2_idx = 5'd10;
        #1;
        while (sb.size() > 0) begin
            cur = sb.pop_front(); obs = observe(cur.sel); checks++;
            if (obs !== cur.val) begin failures++; $display("FAIL %s actual=%h expected=%h", cur.name, obs, cur.val); end
        end
        rst_in = 1'b1;
        push_exp("async_rst_busy_x5", S_R1B, 32'd0);
        push_exp("async_rst_val_x5", S_R1V, 32'd0);
        push_exp("async_rst_val_x10", S_R2V, 32'd0);
        push_exp("async_rst_cnt", S_CNT, 32'd0);
        #2;
        while (sb.size() > 0) begin
            cur = sb.pop_front(); obs = observe(cur.sel); checks++;
            if (obs !== cur.val) begin failures++; $display("FAIL %s actual=%h expected=%h", cur.name, obs, cur.val); end
        end
        @(negedge clk_in);
        rst_in = 1'b0;
        model_reset();
        @(posedge clk_in);
        #1;
    endtask

    task automatic test_rename_commit();
        exp_t cur; logic [31:0] obs;
        issue_valid = 1'b1; issue_rd = 5'd3; issue_tag = 4'd7;
        rs1_idx = 5'd3;
        push_exp("rename_x3_busy", S_R1B, 32'd1);
        push_exp("rename_x3_tag", S_R1T, 32'd7);
        tick();
        idle();
        #1;
        while (sb.size() > 0) begin
            cur = sb.pop_front(); obs = observe(cur.sel); checks++;
            if (obs !== cur.val) begin failures++; $display("FAIL %s actual=%h expected=%h", cur.name, obs, cur.val); end
        end
        commit_valid = 1'b1; commit_tag = 4'd7; commit_rd = 5'd3; commit_val = 32'hDEADBEEF;
`ifdef REGFILE_COMMIT_BYPASS_EN
        push_exp("commit_cycle_x3_val", S_R1V, 32'hDEADBEEF);
        push_exp("commit_cycle_x3_busy", S_R1B, 32'd0);
        push_exp("commit_cycle_x3_tag", S_R1T, 32'd0);
`else
        push_exp("commit_cycle_x3_val", S_R1V, 32'd0);
        push_exp("commit_cycle_x3_busy", S_R1B, 32'd1);
        push_exp("commit_cycle_x3_tag", S_R1T, 32'd7);
`endif
        #1;
        while (sb.size() > 0) begin
            cur = sb.pop_front(); obs = observe(cur.sel); checks++;
            if (obs !== cur.val) begin failures++; $display("FAIL %s actual=%h expected=%h", cur.name, obs, cur.val); end
        end
        push_exp("commit_x3_val", S_R1V, 32'hDEADBEEF);
        push_exp("commit_x3_busy", S_R1B, 32'd0);
        push_exp("commit_x3_tag", S_R1T, 32'd0);
        push_exp("commit_cnt", S_CNT, 32'd1);
        tick();
        idle();
        #1;
        while (sb.size() > 0) begin
            cur = sb.pop_front(); obs = observe(cur.sel); checks++;
            if (obs !== cur.val) begin failures++; $display("FAIL %s actual=%h expected=%h", cur.name, obs, cur.val); end
        end
    endtask

    task automatic test_stale_commit();
        exp_t cur; logic [31:0] obs;
        issue_valid = 1'b1; issue_rd = 5'd4; issue_tag = 4'd2;
        tick();
        issue_tag = 4'd9;
        rs1_idx = 5'd4;
        // Read in the rename cycle still sees the previous producer.
        push_exp("rename_cycle_x4_busy", S_R1B, 32'd1);
        push_exp("rename_cycle_x4_tag", S_R1T, 32'd2);
        #1;
        while (sb.size() > 0) begin
            cur = sb.pop_front(); obs = observe(cur.sel); checks++;
            if (obs !== cur.val) begin failures++; $display("FAIL %s actual=%h expected=%h", cur.name, obs, cur.val); end
        end
        tick();
        idle();
        commit_valid = 1'b1; commit_tag = 4'd2; commit_rd = 5'd4; commit_val = 32'h11;
        push_exp("stale_x4_val", S_R1V, 32'h11);
        push_exp("stale_x4_busy", S_R1B, 32'd1);
        push_exp("stale_x4_tag", S_R1T, 32'd9);
        push_exp("stale_cnt", S_CNT, 32'd2);
        tick();
        idle();
        #1;
        while (sb.size() > 0) begin
            cur = sb.pop_front(); obs = observe(cur.sel); checks++;
            if (obs !== cur.val) begin failures++; $display("FAIL %s actual=%h expected=%h", cur.name, obs, cur.val); end
        end
    endtask

    task automatic test_collision();
        exp_t cur; logic [31:0] obs;
        commit_valid = 1'b1; commit_tag = 4'd5; commit_rd = 5'd6; commit_val = 32'h22;
        issue_valid = 1'b1; issue_rd = 5'd6; issue_tag = 4'd8;
        rs2_idx = 5'd6;
        push_exp("collide_pre_x6_busy", S_R2B, 32'd0);
        push_exp("collide_pre_x6_tag", S_R2T, 32'd0);
        #1;
        while (sb.size() > 0) begin
            cur = sb.pop_front(); obs = observe(cur.sel); checks++;
            if (obs !== cur.val) begin failures++; $display("FAIL %s actual=%h expected=%h", cur.name, obs, cur.val); end
        end
        push_exp("collide_x6_val", S_R2V, 32'h22);
        push_exp("collide_x6_busy", S_R2B, 32'd1);
        push_exp("collide_x6_tag", S_R2T, 32'd8);
        push_exp("collide_cnt", S_CNT, 32'd3);
        tick();
        idle();
        #1;
        while (sb.size() > 0) begin
            cur = sb.pop_front(); obs = observe(cur.sel); checks++;
            if (obs !== cur.val) begin failures++; $display("FAIL %s actual=%h expected=%h", cur.name, obs, cur.val); end
        end
    endtask

    task automatic test_flush();
        exp_t cur; logic [31:0] obs;
        for (int i = 1; i < 32; i++) begin
            issue_valid = 1'b1; issue_rd = 5'(i); issue_tag = 4'(i);
            tick();
        end
        idle();
        predict_fail = 1'b1;
        issue_valid = 1'b1; issue_rd = 5'd7; issue_tag = 4'd3;
        commit_valid = 1'b1; commit_rd = 5'd2; commit_tag = 4'd0; commit_val = 32'h44;
        tick();
        idle();
        for (int i = 1; i < 32; i++) begin
            rs1_idx = 5'(i);
            push_exp($sformatf("flush_x%0d_busy", i), S_R1B, 32'd0);
            push_exp($sformatf("flush_x%0d_tag", i), S_R1T, 32'd0);
            #1;
            while (sb.size() > 0) begin
                cur = sb.pop_front(); obs = observe(cur.sel); checks++;
                if (obs !== cur.val) begin failures++; $display("FAIL %s actual=%h expected=%h", cur.name, obs, cur.val); end
            end
        end
        rs1_idx = 5'd2; rs2_idx = 5'd4;
        push_exp("flush_commit_x2_val", S_R1V, 32'h44);
        push_exp("flush_keep_x4_val", S_R2V, 32'h11);
        push_exp("flush_cnt", S_CNT, 32'd4);
        #1;
        while (sb.size() > 0) begin
            cur = sb.pop_front(); obs = observe(cur.sel); checks++;
            if (obs !== cur.val) begin failures++; $display("FAIL %s actual=%h expected=%h", cur.name, obs, cur.val); end
        end
        rs1_idx = 5'd3; rs2_idx = 5'd6;
        push_exp("flush_keep_x3_val", S_R1V, 32'hDEADBEEF);
        push_exp("flush_keep_x6_val", S_R2V, 32'h22);
        #1;
        while (sb.size() > 0) begin
            cur = sb.pop_front(); obs = observe(cur.sel); checks++;
            if (obs !== cur.val) begin failures++; $display("FAIL %s actual=%h expected=%h", cur.name, obs, cur.val); end
        end
        @(posedge clk_in);
        #1;
    endtask

    task automatic test_x0();
        exp_t cur; logic [31:0] obs;
        issue_valid = 1'b1; issue_rd = 5'd0; issue_tag = 4'd1;
        commit_valid = 1'b1; commit_rd = 5'd0; commit_tag = 4'd1; commit_val = 32'h99;
        rs1_idx = 5'd0; rs2_idx = 5'd0;
        push_exp("x0_rs2_busy", S_R2B, 32'd0);
        push_exp("x0_rs2_tag", S_R2T, 32'd0);
        push_exp("x0_rs2_val", S_R2V, 32'd0);
        push_exp("x0_rs1_val", S_R1V, 32'd0);
        push_exp("x0_commit_cnt", S_CNT, 32'd5);
        tick();
        idle();
        #1;
        while (sb.size() > 0) begin
            cur = sb.pop_front(); obs = observe(cur.sel); checks++;
            if (obs !== cur.val) begin failures++; $display("FAIL %s actual=%h expected=%h", cur.name, obs, cur.val); end
        end
    endtask

    task automatic test_rdy_hold();
        exp_t cur; logic [31:0] obs;
        issue_valid = 1'b1; issue_rd = 5'd12; issue_tag = 4'hC;
        tick();
        idle();
        rdy_in = 1'b0;
        predict_fail = 1'b1;
        issue_valid = 1'b1; issue_rd = 5'd8; issue_tag = 4'd5;
        commit_valid = 1'b1; commit_rd = 5'd12; commit_tag = 4'hC; commit_val = 32'h66;
        rs1_idx = 5'd3;
        push_exp("hold_read_x3_val", S_R1V, 32'hDEADBEEF);
        #1;
        while (sb.size() > 0) begin
            cur = sb.pop_front(); obs = observe(cur.sel); checks++;
            if (obs !== cur.val) begin failures++; $display("FAIL %s actual=%h expected=%h", cur.name, obs, cur.val); end
        end
        push_exp("hold_x12_busy", S_R1B, 32'd1);
        push_exp("hold_x12_tag", S_R1T, 32'hC);
        push_exp("hold_x12_val", S_R1V, 32'd0);
        push_exp("hold_x8_busy", S_R2B, 32'd0);
        push_exp("hold_cnt", S_CNT, 32'd5);
        tick();
        idle();
        rs1_idx = 5'd12; rs2_idx = 5'd8;
        #1;
        while (sb.size() > 0) begin
            cur = sb.pop_front(); obs = observe(cur.sel); checks++;
            if (obs !== cur.val) begin failures++; $display("FAIL %s actual=%h expected=%h", cur.name, obs, cur.val); end
        end
    endtask

    task automatic test_bypass();
        exp_t cur; logic [31:0] obs;
        issue_valid = 1'b1; issue_rd = 5'd9; issue_tag = 4'd4;
        tick();
        idle();
        commit_valid = 1'b1; commit_tag = 4'd4; commit_rd = 5'd9; commit_val = 32'h55;
        rs1_idx = 5'd9; rs2_idx = 5'd9;
`ifdef REGFILE_COMMIT_BYPASS_EN
        push_exp("bypass_rs1_val", S_R1V, 32'h55);
        push_exp("bypass_rs1_busy", S_R1B, 32'd0);
        push_exp("bypass_rs1_tag", S_R1T, 32'd0);
        push_exp("bypass_rs2_val", S_R2V, 32'h55);
`else
        push_exp("nobypass_rs1_val", S_R1V, 32'd0);
        push_exp("nobypass_rs1_busy", S_R1B, 32'd1);
        push_exp("nobypass_rs1_tag", S_R1T, 32'd4);
        push_exp("nobypass_rs2_busy", S_R2B, 32'd1);
`endif
        #1;
        while (sb.size() > 0) begin
            cur = sb.pop_front(); obs = observe(cur.sel); checks++;
            if (obs !== cur.val) begin failures++; $display("FAIL %s actual=%h expected=%h", cur.name, obs, cur.val); end
        end
        push_exp("post_commit_x9_val", S_R1V, 32'h55);
        push_exp("post_commit_x9_busy", S_R1B, 32'd0);
        push_exp("post_commit_cnt", S_CNT, 32'd6);
        tick();
        idle();
        #1;
        while (sb.size() > 0) begin
            cur = sb.pop_front(); obs = observe(cur.sel); checks++;
            if (obs !== cur.val) begin failures++; $display("FAIL %s actual=%h expected=%h", cur.name, obs, cur.val); end
        end
    endtask

    task automatic test_back_to_back();
        exp_t cur; logic [31:0] obs;
        logic [4:0] rd;
        for (int n = 0; n < 300; n++) begin
            rd           = 5'($urandom_range(0, 31));
            rdy_in       = ($urandom_range(0, 7) != 0);
            predict_fail = ($urandom_range(0, 15) == 0);
            commit_valid = $urandom_range(0, 1) == 1;
            commit_rd    = rd;
            commit_tag   = ($urandom_range(0, 1) == 1) ? m_tag[rd] : 4'($urandom_range(0, 15));
            commit_val   = $urandom;
            issue_valid  = $urandom_range(0, 1) == 1;
            issue_rd     = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
            issue_tag    = 4'($urandom_range(0, 15));
            rs1_idx      = ($urandom_range(0, 1) == 1) ? rd : 5'($urandom_range(0, 31));
            rs2_idx      = 5'($urandom_range(0, 31));
            push_exp($sformatf("b2b%0d_rs1_val", n), S_R1V, m_rd_val(rs1_idx));
            push_exp($sformatf("b2b%0d_rs1_busy", n), S_R1B, m_rd_busy(rs1_idx));
            push_exp($sformatf("b2b%0d_rs1_tag", n), S_R1T, m_rd_tag(rs1_idx));
            push_exp($sformatf("b2b%0d_rs2_val", n), S_R2V, m_rd_val(rs2_idx));
            push_exp($sformatf("b2b%0d_rs2_busy", n), S_R2B, m_rd_busy(rs2_idx));
            push_exp($sformatf("b2b%0d_rs2_tag", n), S_R2T, m_rd_tag(rs2_idx));
            push_exp($sformatf("b2b%0d_cnt", n), S_CNT, m_cnt);
            #1;
            while (sb.size() > 0) begin
                cur = sb.pop_front(); obs = observe(cur.sel); checks++;
                if (obs !== cur.val) begin failures++; $display("FAIL %s actual=%h expected=%h", cur.name, obs, cur.val); end
            end
            tick();
        end
        idle();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_rename_commit();
        test_stale_commit();
        test_collision();
        test_flush();
        test_x0();
        test_rdy_hold();
        test_bypass();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
